// File: rtl/legacy_direct_unit.sv
`default_nettype none
// ============================================================================
// Module   : legacy_direct_unit
// Summary  : Registered moving-window summer. out0 is the sum of the last
//            DEPTH samples of in0, narrowed to OW bits. Optional macro
//            LEGACY_DIRECT_SAT_EN makes the narrowing saturate instead of wrap.
// Revision : 1.0 - initial release
// ============================================================================
module legacy_direct_unit #(
  parameter int DEPTH = 6,
  parameter int IW    = 4,
  parameter int OW    = 3
) (
  input  logic          clk,
  input  logic          rstn,   // active-high despite the name
  input  logic [IW-1:0] in0,
  output logic [OW-1:0] out0
);

  localparam int SW = IW + $clog2(DEPTH + 1);

  logic [IW-1:0] hist [DEPTH];
  logic [SW-1:0] sum;
  logic [SW-1:0] next_sum;
  logic [OW-1:0] narrowed;

  // The oldest sample is always part of sum, so this never underflows.
  assign next_sum = sum + SW'(in0) - SW'(hist[DEPTH-1]);

  generate
    if (OW >= SW) begin : g_wide
      assign narrowed = OW'(next_sum);
    end else begin : g_narrow
`ifdef LEGACY_DIRECT_SAT_EN
      localparam logic [SW-1:0] MAX_OUT = SW'((1 << OW) - 1);
      assign narrowed = (next_sum > MAX_OUT) ? '1 : next_sum[OW-1:0];
`else
      assign narrowed = next_sum[OW-1:0];
`endif
    end
  endgenerate

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      sum  <= '0;
      out0 <= '0;
    end else begin
      hist[0] <= in0;
      for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
      sum  <= next_sum;
      out0 <= narrowed;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_legacy_direct_unit.sv
`default_nettype none
// Testbench for legacy_direct_unit: random and directed stimulus, a queue-based
// reference model, and a scoreboard monitor comparing every clock edge.
module tb_legacy_direct_unit;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [3:0] in0 = '0;
  logic [2:0] out0;
  logic [3:0] out1;

  int errors = 0;
  int checks = 0;

  int samples[$];        // model history, newest at front
  int exp6[$];
  int exp1[$];
  bit done = 0;

  legacy_direct_unit #(.DEPTH(6), .IW(4), .OW(3)) u_dut (
    .clk(clk), .rstn(rstn), .in0(in0), .out0(out0));

  legacy_direct_unit #(.DEPTH(1), .IW(4), .OW(4)) u_d1 (
    .clk(clk), .rstn(rstn), .in0(in0), .out0(out1));

  always #10 clk = ~clk;

  function automatic int narrow3(int s);
`ifdef LEGACY_DIRECT_SAT_EN
    return (s > 7) ? 7 : s;
`else
    return s % 8;
`endif
  endfunction

  // Drive one sample ahead of the next rising edge and predict the outputs.
  task automatic step(input int v);
    int s;
    @(negedge clk);
    in0 = v[3:0];
    samples.push_front(v);
    if (samples.size() > 6) void'(samples.pop_back());
    s = 0;
    foreach (samples[i]) s += samples[i];
    exp6.push_back(narrow3(s));
    exp1.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor
  initial begin
    int e;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (rstn) begin
        check("reset_out0", int'(out0), 0);
        check("reset_out1", int'(out1), 0);
      end else if (exp6.size() == 0 || exp1.size() == 0) begin
        check("scoreboard_empty", 0, 1);
      end else begin
        e = exp6.pop_front();
        check("window_sum", int'(out0), e);
        e = exp1.pop_front();
        check("depth1_delay", int'(out1), e);
      end
    end
  end

  initial begin
    // Reset held with random input: outputs stay 0.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in0 = 4'($urandom);
    end
    @(posedge clk);
    #7 rstn = 1'b0;
    samples.delete();

    for (int i = 0; i < 4; i++) step(0);
    for (int i = 0; i < 8; i++) step(1);         // fill
    for (int i = 0; i < 6; i++) step(0);
    step(5);                                     // window exit
    for (int i = 0; i < 7; i++) step(0);
    for (int i = 0; i < 3; i++) step(15);        // narrowing
    for (int i = 0; i < 6; i++) step(0);
    for (int i = 0; i < 6; i++) step(2);         // mid-window reset

    @(posedge clk);
    #3 rstn = 1'b1;
    #2;
    check("async_reset_out0", int'(out0), 0);
    check("async_reset_out1", int'(out1), 0);
    samples.delete();
    #2 rstn = 1'b0;
    step(1);
    step(1);

    for (int i = 0; i < 300; i++) step(int'($urandom_range(0, 15)));

    @(posedge clk);
    #3;
    done = 1;
    check("queue_drained", exp6.size() + exp1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
